i2c_dri: RTL and testbench
==========================

I2C_DRI -- requirements
Module: i2c_dri

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1010000, the 7-bit device address sent in every address byte.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000, the clk frequency in Hz.
REQ-003 SHALL have parameter I2C_FREQ, default 250_000, the SCL frequency in Hz.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i2c_exec, input, 1 bit: one-cycle transaction start request.
REQ-007 SHALL have port bit_ctrl, input, 1 bit: word-address width, 1 = 16-bit, 0 = 8-bit.
REQ-008 SHALL have port i2c_rh_wl, input, 1 bit: 1 = random read, 0 = byte write.
REQ-009 SHALL have port i2c_addr, input, 16 bits: in-device word address.
REQ-010 SHALL have port i2c_data_w, input, 8 bits: byte to write.
REQ-011 SHALL have port i2c_data_r, output, 8 bits: byte read.
REQ-012 SHALL have port i2c_done, output, 1 bit: one-cycle pulse when a transaction ends.
REQ-013 SHALL have port i2c_ack, output, 1 bit: 1 = a NACK was received in the last transaction.
REQ-014 SHALL have port scl, output, 1 bit: I2C clock, push-pull.
REQ-015 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low (open-drain), 0 = release.
REQ-016 SHALL have port sda_i, input, 1 bit: sampled SDA line level.

Function
REQ-017 SHALL derive a quarter-bit tick every CLK_FREQ/(4*I2C_FREQ) clk cycles (50 at defaults), so one SCL bit = 4 ticks = 200 clk.
REQ-018 SHALL run the tick counter only while busy and reset it to 0 on accepting i2c_exec.
REQ-019 SHALL accept i2c_exec only in IDLE, capturing i2c_addr, i2c_data_w, i2c_rh_wl and bit_ctrl in that cycle, clearing i2c_ack, and ignoring i2c_exec while busy.
REQ-020 SHALL implement states IDLE, START, SLADDR, ADDR_H, ADDR_L, DATA_WR, RSTART, SLADDR_RD, DATA_RD and STOP.
REQ-021 SHALL sequence a write as IDLE -> START -> SLADDR -> ADDR_H (only if bit_ctrl=1) -> ADDR_L -> DATA_WR -> STOP -> IDLE.
REQ-022 SHALL sequence a read as IDLE -> START -> SLADDR -> ADDR_H (only if bit_ctrl=1) -> ADDR_L -> RSTART -> SLADDR_RD -> DATA_RD -> STOP -> IDLE.
REQ-023 SHALL, per data bit: tick0 scl=0 and set SDA; tick1 scl=1; tick2 sample sda_i; tick3 scl=0, MSB first.
REQ-024 SHALL release SDA during the 9th (ACK) bit of each transmitted byte and sample it at tick2.
REQ-025 SHALL generate START/RSTART as SDA released with scl=1, then SDA pulled low while scl=1, then scl=0.
REQ-026 SHALL generate STOP as SDA low, then scl=1, then SDA released while scl=1.
REQ-027 SHALL send SLADDR as {SLAVE_ADDR,0} and SLADDR_RD as {SLAVE_ADDR,1}.
REQ-028 SHALL drive i2c_addr[15:8] in ADDR_H and i2c_addr[7:0] in ADDR_L.
REQ-029 SHALL shift DATA_RD bits into i2c_data_r, master-NACK the 9th bit (SDA released), and hold i2c_data_r stable until the next read's DATA_RD.
REQ-030 SHALL, on a sampled ACK bit = 1, set i2c_ack=1 and go directly to STOP, skipping remaining bytes.
REQ-031 SHALL pulse i2c_done high for exactly one clk at the end of STOP, including NACK-aborted transactions, then enter IDLE.
REQ-032 SHALL, in IDLE, hold scl=1 and sda_oe=0.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-transaction, immediately force state=IDLE, scl=1, sda_oe=0, i2c_done=0, i2c_ack=0, i2c_data_r=8'h00 and tick/bit counters=0.

Verification
REQ-034 SHALL pass a 16-bit write: addr 16'h0012, data 8'hA5, ACKing model -> bus bytes A0,00,12,A5, then STOP, one i2c_done pulse, i2c_ack=0.
REQ-035 SHALL pass a 16-bit read: addr 16'h0005, model returns 8'h3C -> bytes A0,00,05, RSTART, A1, master NACK, STOP, i2c_data_r=8'h3C at the i2c_done pulse.
REQ-036 SHALL pass an 8-bit write: bit_ctrl=0, addr 16'h1234, data 8'h5A -> bytes A0,34,5A only.
REQ-037 SHALL handle an address NACK: the model NACKs byte A0 -> STOP immediately, i2c_ack=1, one i2c_done pulse, no further bytes.
REQ-038 SHALL ignore a busy exec: i2c_exec re-pulsed mid-write -> no restart, exactly one i2c_done; the next exec after done is accepted.
REQ-039 SHALL recover from reset mid-transfer: rst_n low during DATA_WR -> scl=1, sda_oe=0 at once; a new write after release completes normally.

Source files
------------

// File: rtl/i2c_dri.sv
// I2C master for byte write / random read with 8- or 16-bit word address.
// Each SCL bit is four quarter-bit ticks; all bus outputs are registered.
module i2c_dri #(
   parameter logic [6:0]  SLAVE_ADDR = 7'b1010000,
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned I2C_FREQ   = 250_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i2c_exec,
   input  logic        bit_ctrl,
   input  logic        i2c_rh_wl,
   input  logic [15:0] i2c_addr,
   input  logic [7:0]  i2c_data_w,
   output logic [7:0]  i2c_data_r,
   output logic        i2c_done,
   output logic        i2c_ack,
   output logic        scl,
   output logic        sda_oe,
   input  logic        sda_i
);

   localparam int unsigned DIV   = CLK_FREQ / (4 * I2C_FREQ);
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [3:0] {
      IDLE, START, SLADDR, ADDR_H, ADDR_L, DATA_WR, RSTART, SLADDR_RD, DATA_RD, STOP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         ph_q, ph_d;
   logic [3:0]         bit_q, bit_d;
   logic               scl_q, scl_d;
   logic               sda_oe_q, sda_oe_d;
   logic               done_q, done_d;
   logic               ack_q, ack_d;
   logic               nack_q, nack_d;
   logic [7:0]         data_r_q, data_r_d;
   logic [15:0]        addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic               rd_q, rd_d;
   logic               wide_q, wide_d;

   logic               tick_c;
   logic [7:0]         tx_byte_c;
   logic               tx_bit_c;
   state_t             after_byte_c;

   assign tick_c = (cnt_q == CNT_W'(DIV - 1));

   // Byte currently being shifted out and the state that follows its ACK
   always_comb begin
      tx_byte_c    = 8'h00;
      after_byte_c = STOP;
      unique case (state_q)
         SLADDR:    begin tx_byte_c = {SLAVE_ADDR, 1'b0}; after_byte_c = wide_q ? ADDR_H : ADDR_L; end
         ADDR_H:    begin tx_byte_c = addr_q[15:8];       after_byte_c = ADDR_L; end
         ADDR_L:    begin tx_byte_c = addr_q[7:0];        after_byte_c = rd_q ? RSTART : DATA_WR; end
         DATA_WR:   begin tx_byte_c = wdata_q;            after_byte_c = STOP; end
         SLADDR_RD: begin tx_byte_c = {SLAVE_ADDR, 1'b1}; after_byte_c = DATA_RD; end
         default:   begin tx_byte_c = 8'h00;              after_byte_c = STOP; end
      endcase
   end

   assign tx_bit_c = tx_byte_c[3'(4'd7 - bit_q)];

   // Next-state and output sequencing, advanced once per quarter-bit tick
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      bit_d    = bit_q;
      scl_d    = scl_q;
      sda_oe_d = sda_oe_q;
      done_d   = 1'b0;
      ack_d    = ack_q;
      nack_d   = nack_q;
      data_r_d = data_r_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wide_d   = wide_q;

      if (state_q == IDLE) begin
         scl_d    = 1'b1;
         sda_oe_d = 1'b0;
         cnt_d    = '0;
         ph_d     = 2'd0;
         bit_d    = 4'd0;
         if (i2c_exec) begin
            addr_d  = i2c_addr;
            wdata_d = i2c_data_w;
            rd_d    = i2c_rh_wl;
            wide_d  = bit_ctrl;
            ack_d   = 1'b0;
            state_d = START;
         end
      end else begin
         cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
         if (tick_c) begin
            ph_d = ph_q + 2'd1;
            unique case (state_q)
               START: begin
                  unique case (ph_q)
                     2'd0: begin scl_d = 1'b1; sda_oe_d = 1'b0; end
                     2'd1: sda_oe_d = 1'b1;
                     2'd2: scl_d = 1'b0;
                     2'd3: begin state_d = SLADDR; bit_d = 4'd0; end
                  endcase
               end
               SLADDR, ADDR_H, ADDR_L, DATA_WR, SLADDR_RD: begin
                  unique case (ph_q)
                     2'd0: begin
                        scl_d    = 1'b0;
                        sda_oe_d = (bit_q < 4'd8) ? ~tx_bit_c : 1'b0;
                     end
                     2'd1: scl_d = 1'b1;
                     2'd2: nack_d = sda_i;
                     2'd3: begin
                        scl_d = 1'b0;
                        if (bit_q == 4'd8) begin
                           bit_d = 4'd0;
                           if (nack_q) begin
                              ack_d   = 1'b1;
                              state_d = STOP;
                           end else begin
                              state_d = after_byte_c;
                           end
                        end else begin
                           bit_d = bit_q + 4'd1;
                        end
                     end
                  endcase
               end
               DATA_RD: begin
                  // SDA stays released for all nine bits; the 9th is the master NACK
                  unique case (ph_q)
                     2'd0: begin scl_d = 1'b0; sda_oe_d = 1'b0; end
                     2'd1: scl_d = 1'b1;
                     2'd2: if (bit_q < 4'd8) data_r_d = {data_r_q[6:0], sda_i};
                     2'd3: begin
                        scl_d = 1'b0;
                        if (bit_q == 4'd8) begin
                           bit_d   = 4'd0;
                           state_d = STOP;
                        end else begin
                           bit_d = bit_q + 4'd1;
                        end
                     end
                  endcase
               end
               RSTART: begin
                  unique case (ph_q)
                     2'd0: begin scl_d = 1'b0; sda_oe_d = 1'b0; end
                     2'd1: scl_d = 1'b1;
                     2'd2: sda_oe_d = 1'b1;
                     2'd3: begin scl_d = 1'b0; state_d = SLADDR_RD; bit_d = 4'd0; end
                  endcase
               end
               STOP: begin
                  unique case (ph_q)
                     2'd0: begin scl_d = 1'b0; sda_oe_d = 1'b1; end
                     2'd1: scl_d = 1'b1;
                     2'd2: sda_oe_d = 1'b0;
                     2'd3: begin done_d = 1'b1; state_d = IDLE; end
                  endcase
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ph_q     <= 2'd0;
         bit_q    <= 4'd0;
         scl_q    <= 1'b1;
         sda_oe_q <= 1'b0;
         done_q   <= 1'b0;
         ack_q    <= 1'b0;
         nack_q   <= 1'b0;
         data_r_q <= 8'h00;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         rd_q     <= 1'b0;
         wide_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         scl_q    <= scl_d;
         sda_oe_q <= sda_oe_d;
         done_q   <= done_d;
         ack_q    <= ack_d;
         nack_q   <= nack_d;
         data_r_q <= data_r_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wide_q   <= wide_d;
      end
   end

   assign i2c_data_r = data_r_q;
   assign i2c_done   = done_q;
   assign i2c_ack    = ack_q;
   assign scl        = scl_q;
   assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_dri.sv
// Bench for i2c_dri: a bus-level slave logs START/STOP/bytes and is compared
// against the expected frame built from the transaction description.
module tb_i2c_dri;

   localparam logic [6:0]  SLV    = 7'b1010000;
   localparam int unsigned CLK_F  = 5_000_000;
   localparam int unsigned I2C_F  = 250_000;
   localparam int unsigned DIV    = CLK_F / (4 * I2C_F);
   localparam int          TOK_S  = 256;
   localparam int          TOK_P  = 257;
   localparam int          TOK_MN = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i2c_exec = 1'b0;
   logic        bit_ctrl = 1'b0;
   logic        i2c_rh_wl = 1'b0;
   logic [15:0] i2c_addr = 16'h0000;
   logic [7:0]  i2c_data_w = 8'h00;
   logic [7:0]  i2c_data_r;
   logic        i2c_done, i2c_ack, scl, sda_oe;
   logic        slv_pull = 1'b0;
   wire         sda_line = !(sda_oe || slv_pull);

   i2c_dri #(.SLAVE_ADDR(SLV), .CLK_FREQ(CLK_F), .I2C_FREQ(I2C_F)) dut (
      .clk(clk), .rst_n(rst_n), .i2c_exec(i2c_exec), .bit_ctrl(bit_ctrl),
      .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
      .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
      .scl(scl), .sda_oe(sda_oe), .sda_i(sda_line)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Slave bus model state
   int         bus_log[$];
   logic       pscl = 1'b1, psda = 1'b1;
   int         bitn = 0;
   logic [7:0] shreg = 8'h00;
   logic       tx = 1'b0, tx_next = 1'b0, first_byte = 1'b0, mack = 1'b0;
   int         rx_cnt = 0;
   int         nack_at = -1;
   logic [7:0] rd_byte = 8'h00;
   int         cyc = 0, last_rise = 0, scl_period = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         slv_pull = 1'b0; bitn = 0; tx = 1'b0; tx_next = 1'b0; first_byte = 1'b0;
      end else if (scl && pscl && psda && !sda_line) begin
         bus_log.push_back(TOK_S);
         bitn = 0; first_byte = 1'b1; tx = 1'b0; tx_next = 1'b0;
      end else if (scl && pscl && !psda && sda_line) begin
         bus_log.push_back(TOK_P);
      end else if (scl && !pscl) begin
         if (bitn >= 1 && bitn <= 7) scl_period = cyc - last_rise;
         last_rise = cyc;
         if (bitn < 8) shreg = {shreg[6:0], sda_line};
         else mack = sda_line;
         bitn++;
      end else if (!scl && pscl) begin
         if (bitn == 8) begin
            if (tx) slv_pull = 1'b0;
            else begin
               bus_log.push_back(int'(shreg));
               slv_pull   = (rx_cnt != nack_at);
               tx_next    = first_byte && shreg[0] && slv_pull;
               first_byte = 1'b0;
               rx_cnt++;
            end
         end else if (bitn == 9) begin
            bitn = 0;
            if (tx) begin
               bus_log.push_back(TOK_MN | int'(mack));
               tx = 1'b0; slv_pull = 1'b0;
            end else if (tx_next) begin
               tx = 1'b1; tx_next = 1'b0; slv_pull = !rd_byte[7];
            end else slv_pull = 1'b0;
         end else if (tx && bitn >= 1) begin
            slv_pull = !rd_byte[3'(7 - bitn)];
         end
      end
      pscl = scl;
      psda = sda_line;
   end

   logic [7:0] last_dr = 8'h00;

   task automatic run_txn(input bit rd, input bit wide, input logic [15:0] addr,
                          input logic [7:0] wd, input int nk, input bit repulse, input int rb);
      int seq[$];
      int exp[$];
      int idx = 0;
      bit nacked = 1'b0;
      int dones = 0, cyc_n = 0, post = 0;
      bit seen = 1'b0;
      logic [7:0] exp_dr;

      seq.push_back(TOK_S);
      seq.push_back(int'({SLV, 1'b0}));
      if (wide) seq.push_back(int'(addr[15:8]));
      seq.push_back(int'(addr[7:0]));
      if (rd) begin
         seq.push_back(TOK_S);
         seq.push_back(int'({SLV, 1'b1}));
         seq.push_back(TOK_MN | 1);
      end else seq.push_back(int'(wd));
      for (int i = 0; i < seq.size() && !nacked; i++) begin
         exp.push_back(seq[i]);
         if (seq[i] < 256) begin
            if (idx == nk) nacked = 1'b1;
            idx++;
         end
      end
      exp.push_back(TOK_P);

      rd_byte = (rb < 0) ? 8'($urandom_range(1, 255)) : 8'(rb);
      exp_dr  = (rd && !nacked) ? rd_byte : last_dr;
      bus_log.delete();
      rx_cnt  = 0;
      nack_at = nk;

      @(negedge clk);
      i2c_exec = 1'b1; bit_ctrl = wide; i2c_rh_wl = rd; i2c_addr = addr; i2c_data_w = wd;
      @(negedge clk);
      i2c_exec = 1'b0;
      while (cyc_n < 4000 && !(seen && post >= 40)) begin
         @(negedge clk);
         cyc_n++;
         if (repulse) begin
            i2c_exec = (cyc_n == 150);
            if (cyc_n == 150) begin
               i2c_addr = 16'($urandom); i2c_data_w = 8'($urandom); i2c_rh_wl = ~rd;
            end
         end
         if (i2c_done) begin
            dones++;
            if (!seen) begin
               check("data_r_at_done", int'(i2c_data_r), int'(exp_dr));
               check("ack_at_done", int'(i2c_ack), int'(nacked));
            end
            seen = 1'b1;
         end
         if (seen) post++;
      end
      i2c_exec = 1'b0;
      check("done_count", dones, 1);
      check("idle_scl", int'(scl), 1);
      check("idle_sda_oe", int'(sda_oe), 0);
      check("bus_len", bus_log.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check("bus_tok", (i < bus_log.size()) ? bus_log[i] : -1, exp[i]);
      last_dr = exp_dr;
   endtask

   task automatic reset_mid();
      int w = 0;
      bus_log.delete();
      rx_cnt = 0; nack_at = -1;
      @(negedge clk);
      i2c_exec = 1'b1; bit_ctrl = 1'b1; i2c_rh_wl = 1'b0;
      i2c_addr = 16'($urandom); i2c_data_w = 8'($urandom);
      @(negedge clk);
      i2c_exec = 1'b0;
      while (bus_log.size() < 4 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check("rst_reach_data_wr", int'(bus_log.size() >= 4), 1);
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_scl", int'(scl), 1);
      check("rst_sda_oe", int'(sda_oe), 0);
      check("rst_done", int'(i2c_done), 0);
      check("rst_ack", int'(i2c_ack), 0);
      check("rst_data_r", int'(i2c_data_r), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_dr = 8'h00;
   endtask

   initial begin
      int nk;
      repeat (3) @(negedge clk);
      check("reset_scl", int'(scl), 1);
      check("reset_sda_oe", int'(sda_oe), 0);
      check("reset_done", int'(i2c_done), 0);
      check("reset_ack", int'(i2c_ack), 0);
      check("reset_data_r", int'(i2c_data_r), 0);
      rst_n = 1'b1;

      run_txn(1'b0, 1'b1, 16'h0012, 8'hA5, -1, 1'b0, -1);
      run_txn(1'b1, 1'b1, 16'h0005, 8'h00, -1, 1'b0, 8'h3C);
      run_txn(1'b0, 1'b0, 16'h1234, 8'h5A, -1, 1'b0, -1);
      run_txn(1'b0, 1'b1, 16'h0040, 8'h11, 0, 1'b0, -1);
      run_txn(1'b0, 1'b1, 16'h0777, 8'h22, -1, 1'b1, -1);
      run_txn(1'b1, 1'b0, 16'h0099, 8'h00, 3, 1'b0, -1);
      run_txn(1'b1, 1'b0, 16'h00AB, 8'h00, -1, 1'b0, -1);
      reset_mid();
      run_txn(1'b0, 1'b1, 16'hBEEF, 8'hC3, -1, 1'b0, -1);

      for (int t = 0; t < 12; t++) begin
         nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), nk,
                 1'($urandom_range(0, 3) == 0), -1);
      end
      check("scl_bit_period", scl_period, int'(4 * DIV));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
